// File: rtl/serial_parity_rx_pkg.sv
// Shared types and constants for the serial odd-parity receiver and its
// matching transmitter.
package serial_parity_rx_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    DONE   = 2'd3
  } rx_state_t;

  // 1 = data ones plus parity bit must be odd (parity bit = XNOR of data).
  localparam bit ODD_PARITY = 1'b1;

  // Ceiling log2, minimum 1 so a counter is never zero bits wide.
  function automatic int clog2(input int value);
    int v;
    int r;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/serial_parity_rx_if.sv
// Serial-in / parallel-out link between the pin logic and the word consumer.
interface serial_parity_rx_if #(
  parameter int DATA_W = 3
);
  logic              start;
  logic              din;
  logic              din_valid;
  logic [DATA_W-1:0] data_out;
  logic              out_valid;
  logic              parity_err;
  logic              busy;
  logic              abort;

  modport master (
    output start, din, din_valid,
    input  data_out, out_valid, parity_err, busy, abort
  );

  modport slave (
    input  start, din, din_valid,
    output data_out, out_valid, parity_err, busy, abort
  );
endinterface

// File: rtl/serial_parity_rx_accum.sv
// Serial parity accumulator: XORs in one bit per enabled cycle and presents
// the parity bit a transmitter would append under the link's convention.
module parity_accum
  import serial_parity_rx_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic din,
  output logic parity_bit
);

  logic acc_q;

  // Running XOR of the bits seen since the last clear; clear wins over enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= 1'b0;
    end else if (clr) begin
      acc_q <= 1'b0;
    end else if (en) begin
      acc_q <= acc_q ^ din;
    end
  end

  assign parity_bit = ODD_PARITY ? ~acc_q : acc_q;

endmodule

// File: rtl/serial_parity_rx.sv
// Deserialises DATA_W data bits plus one odd-parity bit into a parallel word
// with a one-cycle valid pulse and a held parity-error flag.
//
// state  | meaning
// IDLE   | waiting for start; serial line ignored
// DATA   | collecting data bits on din_valid cycles
// PARITY | waiting for the parity bit
// DONE   | one cycle, out_valid high, new word and error flag presented
module serial_parity_rx
  import serial_parity_rx_pkg::*;
#(
  parameter int DATA_W    = 3,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic              clk,
  input logic              rst,
  serial_parity_rx_if.slave bus
);

  localparam int                 CNT_W    = clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DATA_W - 1);

  rx_state_t         state_q;
  rx_state_t         state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] shreg_q;
  logic [DATA_W-1:0] data_q;
  logic              out_valid_q;
  logic              parity_err_q;
  logic              abort_q;

  logic              frame_clr;
  logic              bit_en;
  logic              par_en;
  logic              abort_d;
  logic              par_bit;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and per-cycle strobes; start always restarts a frame and only
  // counts as an abort when a frame was actually in progress.
  always_comb begin
    state_d   = state_q;
    frame_clr = 1'b0;
    bit_en    = 1'b0;
    par_en    = 1'b0;
    abort_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d   = DATA;
          frame_clr = 1'b1;
        end
      end
      DATA: begin
        if (bus.start) begin
          frame_clr = 1'b1;
          abort_d   = 1'b1;
        end else if (bus.din_valid) begin
          bit_en = 1'b1;
          if (cnt_q == CNT_LAST) state_d = PARITY;
        end
      end
      PARITY: begin
        if (bus.start) begin
          state_d   = DATA;
          frame_clr = 1'b1;
          abort_d   = 1'b1;
        end else if (bus.din_valid) begin
          par_en  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.start) begin
          state_d   = DATA;
          frame_clr = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Bit counter and shift register for the frame in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      shreg_q <= '0;
    end else if (frame_clr) begin
      cnt_q   <= '0;
      shreg_q <= '0;
    end else if (bit_en) begin
      cnt_q <= cnt_q + 1'b1;
      if (MSB_FIRST) begin
        shreg_q <= {shreg_q[DATA_W-2:0], bus.din};
      end else begin
        shreg_q <= {bus.din, shreg_q[DATA_W-1:1]};
      end
    end
  end

  parity_accum u_accum (
    .clk        (clk),
    .rst        (rst),
    .clr        (frame_clr),
    .en         (bit_en),
    .din        (bus.din),
    .parity_bit (par_bit)
  );

  // Registered outputs; word and error flag load together as DONE is entered
  // and hold until the next completed frame, even if that frame is errored.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q       <= '0;
      parity_err_q <= 1'b0;
      out_valid_q  <= 1'b0;
      abort_q      <= 1'b0;
    end else begin
      out_valid_q <= par_en;
      abort_q     <= abort_d;
      if (par_en) begin
        data_q       <= shreg_q;
        parity_err_q <= bus.din ^ par_bit;
      end
    end
  end

  assign bus.data_out   = data_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.parity_err = parity_err_q;
  assign bus.abort      = abort_q;
  assign bus.busy       = (state_q == DATA) || (state_q == PARITY);

endmodule

// File: tb/tb_serial_parity_rx.sv
// Bench for serial_parity_rx: an MSB-first and an LSB-first instance share
// one stimulus stream and are checked every cycle against a frame-level model.
module tb_serial_parity_rx;

  localparam int DW = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  serial_parity_rx_if #(.DATA_W(DW)) bus_m ();
  serial_parity_rx_if #(.DATA_W(DW)) bus_l ();

  assign bus_l.start     = bus_m.start;
  assign bus_l.din       = bus_m.din;
  assign bus_l.din_valid = bus_m.din_valid;

  serial_parity_rx #(.DATA_W(DW), .MSB_FIRST(1'b1)) dut_m (
    .clk (clk),
    .rst (rst),
    .bus (bus_m.slave)
  );

  serial_parity_rx #(.DATA_W(DW), .MSB_FIRST(1'b0)) dut_l (
    .clk (clk),
    .rst (rst),
    .bus (bus_l.slave)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Frame-level model: bits collected since start, and last completed frame.
  bit          in_frame = 1'b0;
  bit          q[$];
  logic [DW-1:0] exp_data_m = '0;
  logic [DW-1:0] exp_data_l = '0;
  logic        exp_err   = 1'b0;
  logic        exp_ov    = 1'b0;
  logic        exp_abort = 1'b0;
  bit          chk_en    = 1'b0;
  int          ov_cnt    = 0;
  int          abort_cnt = 0;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_chk++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else
      n_pass++;
  endfunction

  function automatic void model_update(input logic r, input logic s,
                                       input logic d, input logic v);
    int ones;
    exp_ov    = 1'b0;
    exp_abort = 1'b0;
    if (r) begin
      q.delete();
      in_frame   = 1'b0;
      exp_data_m = '0;
      exp_data_l = '0;
      exp_err    = 1'b0;
    end else if (s) begin
      if (in_frame) exp_abort = 1'b1;
      q.delete();
      in_frame = 1'b1;
    end else if (in_frame && v) begin
      q.push_back(d);
      if (q.size() == DW + 1) begin
        ones = 0;
        for (int i = 0; i < DW + 1; i++) ones += int'(q[i]);
        for (int i = 0; i < DW; i++) begin
          exp_data_m[DW-1-i] = q[i];
          exp_data_l[i]      = q[i];
        end
        exp_err  = (ones % 2 == 0);
        exp_ov   = 1'b1;
        in_frame = 1'b0;
        q.delete();
      end
    end
  endfunction

  // Compare both instances against the model every cycle, away from the edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("m.data_out",   32'(bus_m.data_out),   32'(exp_data_m));
      check("m.parity_err", 32'(bus_m.parity_err), 32'(exp_err));
      check("m.out_valid",  32'(bus_m.out_valid),  32'(exp_ov));
      check("m.abort",      32'(bus_m.abort),      32'(exp_abort));
      check("m.busy",       32'(bus_m.busy),       32'(in_frame));
      check("l.data_out",   32'(bus_l.data_out),   32'(exp_data_l));
      check("l.parity_err", 32'(bus_l.parity_err), 32'(exp_err));
      check("l.out_valid",  32'(bus_l.out_valid),  32'(exp_ov));
      check("l.abort",      32'(bus_l.abort),      32'(exp_abort));
      check("l.busy",       32'(bus_l.busy),       32'(in_frame));
      if (bus_m.out_valid === 1'b1) ov_cnt++;
      if (bus_m.abort === 1'b1) abort_cnt++;
    end
  end

  task automatic step(input logic s, input logic d, input logic v, input logic r);
    rst             = r;
    bus_m.start     = s;
    bus_m.din       = d;
    bus_m.din_valid = v;
    @(posedge clk);
    model_update(r, s, d, v);
    #1;
  endtask

  // f = {first data bit, ..., last data bit, parity}; gap stall cycles before each bit.
  task automatic send_frame(input logic [DW:0] f, input int gap);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = DW; i >= 0; i--) begin
      repeat (gap) step(1'b0, 1'($urandom), 1'b0, 1'b0);
      step(1'b0, f[i], 1'b1, 1'b0);
    end
  endtask

  logic [DW:0] good [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b0111,
                            4'b1000, 4'b1011, 4'b1101, 4'b1110};
  int c0;
  int a0;

  initial begin
    bus_m.start     = 1'b0;
    bus_m.din       = 1'b0;
    bus_m.din_valid = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk_en = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("rst data_out",  32'(bus_m.data_out),   32'd0);
    check("rst out_valid", 32'(bus_m.out_valid),  32'd0);
    check("rst busy",      32'(bus_m.busy),       32'd0);
    check("rst err",       32'(bus_m.parity_err), 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 8; i++) begin
      send_frame(good[i], 0);
      check("pat out_valid", 32'(bus_m.out_valid),  32'd1);
      check("pat data_out",  32'(bus_m.data_out),   32'(i));
      check("pat err",       32'(bus_m.parity_err), 32'd0);
      step(1'b0, 1'b0, 1'b0, 1'b0);
    end

    send_frame(4'b1010, 0);
    check("bad data_out", 32'(bus_m.data_out),   32'(3'b101));
    check("bad err",      32'(bus_m.parity_err), 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("bad err held", 32'(bus_m.parity_err), 32'd1);
    send_frame(4'b1101, 0);
    check("recover err",  32'(bus_m.parity_err), 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    c0 = ov_cnt;
    send_frame(4'b0111, 2);
    check("gap data_out", 32'(bus_m.data_out),   32'(3'b011));
    check("gap err",      32'(bus_m.parity_err), 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("gap ov pulses", 32'(ov_cnt - c0), 32'd1);

    c0 = ov_cnt;
    a0 = abort_cnt;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    send_frame(4'b0100, 0);
    check("abort data_out", 32'(bus_m.data_out),   32'(3'b010));
    check("abort err",      32'(bus_m.parity_err), 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("abort pulses",   32'(abort_cnt - a0), 32'd1);
    check("abort ov count", 32'(ov_cnt - c0),    32'd1);

    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    check("mid rst data_out", 32'(bus_m.data_out),   32'd0);
    check("mid rst busy",     32'(bus_m.busy),       32'd0);
    check("mid rst abort",    32'(bus_m.abort),      32'd0);
    check("mid rst ov",       32'(bus_m.out_valid),  32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(4'b1000, 0);
    check("post rst data_out", 32'(bus_m.data_out), 32'(3'b100));
    check("post rst err",      32'(bus_m.parity_err), 32'd0);
    check("lsb data_out",      32'(bus_l.data_out), 32'(3'b001));
    check("lsb err",           32'(bus_l.parity_err), 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    c0 = ov_cnt;
    repeat (2000) begin
      step(1'($urandom_range(0, 11) == 0), 1'($urandom),
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 199) == 0));
    end
    check("random frames seen", 32'(ov_cnt - c0 > 50), 32'd1);
    repeat (8) step(1'b0, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/serial_parity_rx.md
Name: serial_parity_rx

Overview:
- Receive end of the odd-parity link whose transmit side computes the parity bit as the 3-input XNOR of the data bits.
- Deserialises a frame of DATA_W data bits followed by one parity bit, arriving on a 1-bit serial line with a qualifier.
- Presents the parallel word with a one-cycle valid pulse and a parity-error flag.
- Sits between the serial pin logic and the downstream consumer of the parallel word.

Parameters:
- DATA_W, 3: number of data bits per frame (legal range 2..16).
- MSB_FIRST, 1: 1 = first data bit received is data_out[DATA_W-1]; 0 = first data bit received is data_out[0].

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  frame-start marker, one cycle wide; din is not sampled in this cycle.
- din  input  1  serial data or parity bit.
- din_valid  input  1  din is sampled only when this is 1.
- data_out  output  DATA_W  last completed frame's data word.
- out_valid  output  1  one-cycle pulse when a frame completes.
- parity_err  output  1  parity result of the last completed frame; valid with out_valid and held after it.
- busy  output  1  1 while in DATA or PARITY.
- abort  output  1  one-cycle pulse when start arrives mid-frame.

Behaviour:
- Reset: on the clk edge with rst=1, go to IDLE; shift register, bit counter and parity accumulator = 0; data_out=0, out_valid=0, parity_err=0, busy=0, abort=0. rst has priority over all other inputs.
- IDLE:
  - start=1 → DATA; bit counter=0; accumulator=0.
  - Otherwise din/din_valid are ignored.
- DATA:
  - On each cycle with din_valid=1: shift din in per MSB_FIRST; accumulator ^= din; counter++.
  - When the DATA_W-th bit is sampled → PARITY.
  - din_valid=0 cycles are stalls with no state change; there is no timeout.
- PARITY:
  - On the first cycle with din_valid=1, go to DONE.
  - Register err = ~(accumulator ^ din), i.e. parity is odd: data ones plus parity bit must be odd. Equivalently, the expected parity bit is the XNOR of the data bits.
- DONE (exactly one cycle):
  - out_valid=1; data_out and parity_err update in this same cycle.
  - Next state → IDLE, or → DATA if start=1 in this cycle.
- Latency: out_valid asserts in the cycle after the parity bit is sampled.
- Output hold: data_out and parity_err hold until the next DONE. On an errored frame, data_out still updates.
- start while in DATA or PARITY:
  - Discard the partial frame and pulse abort for 1 cycle.
  - Restart DATA with counter=0; no out_valid for the aborted frame.
  - din in the start cycle is not sampled, even if din_valid=1.
- busy: combinational from state (DATA or PARITY). out_valid and abort are registered.
- Reset mid-frame: the frame is lost with no out_valid or abort, and all outputs return to reset values.
- Counter width: clog2(DATA_W+1); wrap is unreachable.

Decomposition:
- Shared package/header:
  - state encodings IDLE=2'd0, DATA=2'd1, PARITY=2'd2, DONE=2'd3;
  - the odd-parity convention constant ODD_PARITY=1;
  - the clog2 function.
- One natural sub-module: parity_accum, a serial XOR/XNOR accumulator with clear and enable. It is reusable by the matching transmitter to generate the parity bit.

Test Plan (DATA_W=3, MSB_FIRST=1):
- Reset, then all 8 data patterns with correct parity (000→p1, 001→p0, 010→p0, 011→p1, 100→p0, 101→p1, 110→p1, 111→p0), din_valid continuous → out_valid one cycle after each parity bit; data_out = the pattern; parity_err=0.
- Frame 101 with parity 0 → data_out=3'b101, parity_err=1. A following frame 110 with parity 1 → parity_err returns to 0.
- Frame 011 p1 with din_valid=0 gaps of 2 cycles between every bit → same result as the ungapped frame; busy=1 throughout; out_valid exactly one pulse.
- Start, bits 1,1, then start again, then 010 p0 → abort pulses once; single out_valid with data_out=3'b010, parity_err=0.
- rst asserted after 2 data bits of frame 111 → all outputs 0 next cycle, busy=0. A fresh frame 100 p0 then decodes correctly.
- MSB_FIRST=0 build: send bits 1,0,0 then parity 0 → data_out=3'b001, parity_err=0.
